// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_arb_pkg: FSM encoding, stats width and saturating increment for fifo_wr_arbiter
package fifo_arb_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, ARB = 2'd1, STALL = 2'd2} arb_state_e;
   localparam int STAT_W = 16;
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return &v ? v : v + 1'b1;
   endfunction
endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: producer/consumer side (master) and arbiter side (slave) signals
// FIFO_ARB_STATS_EN adds the grant/stall counter outputs
interface fifo_wr_arbiter_if
   import fifo_arb_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int N_REQ = 4,
   parameter int DEPTH = 8
);
   logic [N_REQ-1:0]           req;
   logic [N_REQ*WIDTH-1:0]     req_data;
   logic [N_REQ-1:0]           grant;
   logic                       fifo_wr_en;
   logic [WIDTH-1:0]           fifo_data;
   logic                       rd_ack;
   logic [$clog2(DEPTH+1)-1:0] credits;
   logic                       stall;
   logic                       credit_err;
`ifdef FIFO_ARB_STATS_EN
   logic [N_REQ*STAT_W-1:0]    grant_cnt;
   logic [STAT_W-1:0]          stall_cnt;
   modport master (output req, req_data, rd_ack,
                   input grant, fifo_wr_en, fifo_data, credits, stall, credit_err, grant_cnt, stall_cnt);
   modport slave  (input req, req_data, rd_ack,
                   output grant, fifo_wr_en, fifo_data, credits, stall, credit_err, grant_cnt, stall_cnt);
`else
   modport master (output req, req_data, rd_ack,
                   input grant, fifo_wr_en, fifo_data, credits, stall, credit_err);
   modport slave  (input req, req_data, rd_ack,
                   output grant, fifo_wr_en, fifo_data, credits, stall, credit_err);
`endif
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: first set request scanning upward from the slot after the last grantee
module rr_pick #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         i_req,
   input  logic [$clog2(N_REQ)-1:0] i_last,
   output logic [N_REQ-1:0]         o_win,
   output logic [$clog2(N_REQ)-1:0] o_idx
);
   localparam int IW = $clog2(N_REQ);
   logic          w_found;
   logic [IW-1:0] w_pos;
   always_comb begin
      o_win = '0;
      o_idx = '0;
      w_found = 1'b0;
      w_pos = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         w_pos = IW'((int'(i_last) + k) % N_REQ);
         if (!w_found && i_req[w_pos]) begin
            w_found = 1'b1;
            o_win[w_pos] = 1'b1;
            o_idx = w_pos;
         end
      end
   end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin sharing of one FIFO write port, credit-based flow control
// FIFO_ARB_STATS_EN adds saturating per-requester grant counts and a stall-cycle count
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int N_REQ = 4,
   parameter int DEPTH = 8
) (
   input logic              clk,
   input logic              rst,
   fifo_wr_arbiter_if.slave arb
);
   localparam int IW = $clog2(N_REQ);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   arb_state_e       r_state, w_next;
   logic [IW-1:0]    r_last, w_idx;
   logic [N_REQ-1:0] w_win, w_grant;
   logic [CW-1:0]    r_credits, w_cred_nx;
   logic [WIDTH-1:0] r_data;
   logic             r_wr_en, r_err, w_ok, w_over, w_stall;

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .i_req (arb.req),
      .i_last(r_last),
      .o_win (w_win),
      .o_idx (w_idx)
   );

   // Grant and rd_ack together cancel; an ack with nothing outstanding is an error
   always_comb begin
      w_ok = !rst && (|arb.req) && (r_credits != '0);
      w_over = arb.rd_ack && !w_ok && (r_credits == FULL);
      w_cred_nx = (w_ok == arb.rd_ack || w_over) ? r_credits
                : w_ok ? r_credits - 1'b1 : r_credits + 1'b1;
   end

   always_ff @(posedge clk)
      r_state <= rst ? IDLE : w_next;

   // Looking at next-cycle credits lets STALL coincide exactly with credits==0
   always_comb
      w_next = (r_state == STALL && w_cred_nx == '0) ? STALL
             : !(|arb.req) ? IDLE
             : (w_cred_nx != '0) ? ARB : STALL;

   always_comb begin
      w_stall = (r_state == STALL);
      w_grant = w_ok ? w_win : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_credits <= FULL;
         r_last <= IW'(N_REQ-1);
         r_wr_en <= 1'b0;
         r_data <= '0;
         r_err <= 1'b0;
      end else begin
         r_credits <= w_cred_nx;
         r_wr_en <= w_ok;
         r_err <= r_err | w_over;
         if (w_ok) begin
            r_last <= w_idx;
            r_data <= arb.req_data[int'(w_idx)*WIDTH +: WIDTH];
         end
      end
   end

   assign arb.grant = w_grant;
   assign arb.fifo_wr_en = r_wr_en;
   assign arb.fifo_data = r_data;
   assign arb.credits = r_credits;
   assign arb.stall = w_stall;
   assign arb.credit_err = r_err;

`ifdef FIFO_ARB_STATS_EN
   logic [N_REQ-1:0][STAT_W-1:0] r_gcnt;
   logic [STAT_W-1:0]            r_scnt;
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_REQ; i++)
         r_gcnt[i] <= rst ? '0 : w_grant[i] ? sat_inc(r_gcnt[i]) : r_gcnt[i];
      r_scnt <= rst ? '0 : w_stall ? sat_inc(r_scnt) : r_scnt;
   end
   assign arb.grant_cnt = r_gcnt;
   assign arb.stall_cnt = r_scnt;
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scenarios plus randomized traffic against a queue-based reference
module tb_fifo_wr_arbiter;
   localparam int W = 8, N = 4, D = 8;
   logic clk = 1'b0, rst = 1'b1;
   int n_cmp = 0, n_bad = 0;
   int m_cred, m_last;
   logic m_err, m_stall, m_wr;
   logic [W-1:0] m_data;
   logic [W-1:0] q[$];

   always #5 clk = ~clk;

   fifo_wr_arbiter_if #(.WIDTH(W), .N_REQ(N), .DEPTH(D)) bus ();
   fifo_wr_arbiter #(.WIDTH(W), .N_REQ(N), .DEPTH(D)) dut (.clk(clk), .rst(rst), .arb(bus.slave));

   function automatic int rr_win(logic [N-1:0] r, int last);
      for (int k = 1; k <= N; k++)
         if (r[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   function automatic logic [N-1:0] exp_grant();
      int w;
      w = rr_win(bus.req, m_last);
      return (!rst && m_cred > 0 && w >= 0) ? N'(1 << w) : '0;
   endfunction

   // Advance model and FIFO across one rising edge; returns at edge+1
   task automatic tick();
      logic wr, ack, r;
      logic [W-1:0] d, junk;
      logic [N*W-1:0] rd;
      int w;
      wr = bus.fifo_wr_en; d = bus.fifo_data; ack = bus.rd_ack; r = rst; rd = bus.req_data;
      w = (m_cred > 0) ? rr_win(bus.req, m_last) : -1;
      if (r) begin
         m_cred = D; m_last = N-1; m_err = 0; m_stall = 0; m_wr = 0; m_data = '0;
      end else begin
         m_wr = (w >= 0);
         if (w >= 0) begin m_data = rd[w*W +: W]; m_last = w; end
         if (w >= 0 && !ack) m_cred--;
         else if (w < 0 && ack) begin
            if (m_cred == D) m_err = 1; else m_cred++;
         end
         m_stall = (m_cred == 0) && ((|bus.req) || m_stall);
      end
      @(posedge clk); #1;
      if (r) q.delete();
      else begin
         if (ack && q.size() > 0) junk = q.pop_front();
         if (wr) q.push_back(d);
      end
   endtask

   task automatic do_reset();
      rst = 1; bus.req = '0; bus.req_data = '0; bus.rd_ack = 0;
      tick(); tick();
      rst = 0;
   endtask

   task automatic test_reset();
      rst = 1; bus.rd_ack = 0;
      bus.req = N'($urandom_range(1, 15)); bus.req_data = $urandom;
      tick(); tick(); #1;
      n_cmp++;
      if ({bus.grant, bus.credits, bus.fifo_wr_en, bus.fifo_data, bus.credit_err, bus.stall} !== {4'b0, 4'd8, 1'b0, 8'h00, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL reset_state: got grant=%b cred=%0d wr=%b data=%h err=%b stall=%b, want 0000/8/0/00/0/0",
                  bus.grant, bus.credits, bus.fifo_wr_en, bus.fifo_data, bus.credit_err, bus.stall);
      end
      rst = 0; bus.req = '0; #1;
      n_cmp++;
      if (bus.grant !== '0) begin n_bad++; $display("FAIL reset_idle_grant: got %b want 0000", bus.grant); end
      tick();
   endtask

   task automatic test_fill();
      do_reset();
      bus.req = 4'b1111; bus.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
      for (int c = 0; c < 9; c++) begin
         #1;
         n_cmp++;
         if ({bus.grant, bus.credits, bus.stall} !== {(c < 8 ? 4'(1 << (c % 4)) : 4'b0), 4'(8 - c), c == 8}) begin
            n_bad++;
            $display("FAIL fill_cycle%0d: got grant=%b cred=%0d stall=%b, want grant=%b cred=%0d stall=%b",
                     c + 1, bus.grant, bus.credits, bus.stall, (c < 8 ? 4'(1 << (c % 4)) : 4'b0), 8 - c, c == 8);
         end
         tick();
      end
      n_cmp++;
      if (q.size() != 8) begin n_bad++; $display("FAIL fill_fifo_size: got %0d want 8", q.size()); end
      for (int i = 0; i < 8 && i < q.size(); i++) begin
         n_cmp++;
         if (q[i] !== 8'(8'h10 + i % 4)) begin n_bad++; $display("FAIL fill_fifo_word%0d: got %h want %h", i, q[i], 8'(8'h10 + i % 4)); end
      end
`ifdef FIFO_ARB_STATS_EN
      n_cmp++;
      if ({bus.grant_cnt, bus.stall_cnt} !== {{4{16'd2}}, 16'd1}) begin
         n_bad++; $display("FAIL stats_fill: got gcnt=%h scnt=%0d want 2 each / 1", bus.grant_cnt, bus.stall_cnt);
      end
`endif
   endtask

   task automatic test_single_credit();
      bus.rd_ack = 1; #1;
      n_cmp++;
      if ({bus.grant, bus.stall} !== {4'b0, 1'b1}) begin n_bad++; $display("FAIL one_credit_ack: got grant=%b stall=%b want 0000/1", bus.grant, bus.stall); end
      tick();
      bus.rd_ack = 0; #1;
      n_cmp++;
      if ({bus.grant, bus.credits, bus.stall} !== {4'b0001, 4'd1, 1'b0}) begin
         n_bad++; $display("FAIL one_credit_grant: got grant=%b cred=%0d stall=%b want 0001/1/0", bus.grant, bus.credits, bus.stall);
      end
      tick();
      n_cmp++;
      if ({bus.fifo_wr_en, bus.fifo_data, bus.credits, bus.stall} !== {1'b1, 8'h10, 4'd0, 1'b1}) begin
         n_bad++; $display("FAIL one_credit_write: got wr=%b data=%h cred=%0d stall=%b want 1/10/0/1", bus.fifo_wr_en, bus.fifo_data, bus.credits, bus.stall);
      end
   endtask

   task automatic test_single_req();
      logic [W-1:0] d;
      do_reset();
      bus.req = 4'b0100; bus.rd_ack = 1;
      for (int c = 0; c < 10; c++) begin
         d = W'($urandom);
         bus.req_data = {$urandom} ^ {8'h00, d, 16'h0000};
         bus.req_data[2*W +: W] = d;
         #1;
         n_cmp++;
         if ({bus.grant, bus.credits} !== {4'b0100, 4'd8}) begin n_bad++; $display("FAIL single_grant%0d: got %b/%0d want 0100/8", c, bus.grant, bus.credits); end
         tick();
         n_cmp++;
         if ({bus.fifo_wr_en, bus.fifo_data, bus.credit_err} !== {1'b1, d, 1'b0}) begin
            n_bad++; $display("FAIL single_data%0d: got wr=%b data=%h err=%b want 1/%h/0", c, bus.fifo_wr_en, bus.fifo_data, bus.credit_err, d);
         end
      end
   endtask

   task automatic test_grant_ack();
      do_reset();
      bus.req = 4'b0001; bus.req_data = $urandom;
      repeat (7) tick();
      bus.rd_ack = 1; #1;
      n_cmp++;
      if ({bus.grant, bus.credits} !== {4'b0001, 4'd1}) begin n_bad++; $display("FAIL gack_pre: got %b/%0d want 0001/1", bus.grant, bus.credits); end
      tick();
      bus.rd_ack = 0; #1;
      n_cmp++;
      if ({bus.credits, bus.stall, bus.grant} !== {4'd1, 1'b0, 4'b0001}) begin
         n_bad++; $display("FAIL gack_post: got cred=%0d stall=%b grant=%b want 1/0/0001", bus.credits, bus.stall, bus.grant);
      end
      tick();
   endtask

   task automatic test_credit_err();
      do_reset();
      bus.req = 4'b0001; bus.req_data = $urandom; bus.rd_ack = 1;
      tick();
      n_cmp++;
      if ({bus.credit_err, bus.credits} !== {1'b0, 4'd8}) begin n_bad++; $display("FAIL err_with_grant: got err=%b cred=%0d want 0/8", bus.credit_err, bus.credits); end
      bus.req = '0; tick();
      n_cmp++;
      if ({bus.credit_err, bus.credits} !== {1'b1, 4'd8}) begin n_bad++; $display("FAIL err_set: got err=%b cred=%0d want 1/8", bus.credit_err, bus.credits); end
      bus.rd_ack = 0; bus.req = 4'b1010;
      repeat (5) tick();
      n_cmp++;
      if ({bus.credit_err, bus.credits} !== {1'b1, 4'd3}) begin n_bad++; $display("FAIL err_sticky: got err=%b cred=%0d want 1/3", bus.credit_err, bus.credits); end
      do_reset();
      n_cmp++;
      if (bus.credit_err !== 1'b0) begin n_bad++; $display("FAIL err_clear: got %b want 0", bus.credit_err); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.req = 4'b1111; bus.req_data = $urandom;
      repeat (3) tick();
      rst = 1; #1;
      n_cmp++;
      if (bus.grant !== '0) begin n_bad++; $display("FAIL mid_rst_grant: got %b want 0000", bus.grant); end
      tick();
      n_cmp++;
      if ({bus.credits, bus.fifo_wr_en, bus.grant} !== {4'd8, 1'b0, 4'b0}) begin
         n_bad++; $display("FAIL mid_rst_state: got cred=%0d wr=%b grant=%b want 8/0/0000", bus.credits, bus.fifo_wr_en, bus.grant);
      end
      rst = 0; #1;
      n_cmp++;
      if (bus.grant !== 4'b0001) begin n_bad++; $display("FAIL mid_rst_first: got %b want 0001", bus.grant); end
      tick();
   endtask

   task automatic test_random();
      logic [N-1:0] pend, g;
      do_reset();
      pend = '0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++)
            if (!pend[i] && $urandom_range(0, 1)) begin pend[i] = 1; bus.req_data[i*W +: W] = W'($urandom); end
         bus.req = pend;
         bus.rd_ack = (q.size() > 0) && ($urandom_range(0, 2) == 0);
         #1;
         n_cmp++;
         if ({bus.grant, bus.credits, bus.stall} !== {exp_grant(), 4'(m_cred), m_stall}) begin
            n_bad++; $display("FAIL rand_comb%0d: got grant=%b cred=%0d stall=%b want %b/%0d/%b",
                              c, bus.grant, bus.credits, bus.stall, exp_grant(), m_cred, m_stall);
         end
         g = bus.grant;
         tick();
         pend &= ~g;
         n_cmp++;
         if ({bus.fifo_wr_en, bus.fifo_data, bus.credit_err} !== {m_wr, m_data, m_err} || q.size() + int'(bus.fifo_wr_en) != D - int'(bus.credits)) begin
            n_bad++; $display("FAIL rand_reg%0d: got wr=%b data=%h err=%b occ=%0d want %b/%h/%b occ=%0d",
                              c, bus.fifo_wr_en, bus.fifo_data, bus.credit_err, q.size(), m_wr, m_data, m_err, D - int'(bus.credits) - int'(bus.fifo_wr_en));
         end
      end
   endtask

   initial begin
      bus.req = '0; bus.req_data = '0; bus.rd_ack = 0;
      test_reset();
      test_fill();
      test_single_credit();
      test_single_req();
      test_grant_ack();
      test_credit_err();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
